gate_sweep_ctrl: RTL

Self-checking sequencer for a combinational gate under test. On `start`, the block drives every input combination of an N-input gate in ascending binary order, holding each vector for a programmable dwell time. It compares the gate output against a latched truth table and reports an error count, the first failing vector, and a pass flag. It replaces hand-written stimulus sequences in gate benches and on-board self-test wrappers for the basic-gate library.

---
 rtl/gate_sweep_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N-input combinational gate: drives every
// input vector in ascending order, checks the gate output against a latched table.
//
// state | meaning
// IDLE  | waiting for start, results from the last sweep held
// DRIVE | vector applied, dwell timer counting down
// CHECK | vector still applied, gate_y compared with the latched table
// DONE  | one-cycle completion pulse, pass flag valid
module gate_sweep_ctrl #(
  parameter int N_IN  = 2,
  parameter int DWELL = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   truth_tbl,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      fail_vec,
  output logic                 fail_valid
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   DW_LOAD  = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(2**N_IN - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t              state;
  logic [2**N_IN-1:0]  tbl;
  logic [CW-1:0]       dwell_cnt;
  logic                mismatch;

  // gate_in doubles as the vector index, so the check always uses what is driven
  assign mismatch = gate_y ^ tbl[gate_in];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tbl        <= '0;
      dwell_cnt  <= '0;
      gate_in    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            tbl        <= truth_tbl;
            dwell_cnt  <= DW_LOAD;
            gate_in    <= '0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            gate_in <= '0;
          end
        end

        DRIVE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gate_in <= '0;
            pass    <= 1'b0;
          end else if (dwell_cnt == '0) begin
            state <= CHECK;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end

        CHECK: begin
          // abort takes priority, so an aborted CHECK is not scored
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gate_in <= '0;
            pass    <= 1'b0;
          end else begin
            if (mismatch) begin
              err_cnt <= err_cnt + (N_IN+1)'(1);
              if (!fail_valid) begin
                fail_vec   <= gate_in;
                fail_valid <= 1'b1;
              end
            end
            if (gate_in == LAST_VEC) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              gate_in <= '0;
              pass    <= (err_cnt == '0) && !mismatch;
            end else begin
              state     <= DRIVE;
              gate_in   <= gate_in + 1'b1;
              dwell_cnt <= DW_LOAD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
